// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding, instruction opcodes, ALU codes and the control-word layout
// used by control_sequencer, ctrl_decode and datapath.
package cpu_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t T0   = 4'd0;
    localparam state_t T1   = 4'd1;
    localparam state_t T2   = 4'd2;
    localparam state_t T3   = 4'd3;
    localparam state_t T4   = 4'd4;
    localparam state_t T5   = 4'd5;
    localparam state_t T6   = 4'd6;
    localparam state_t T7   = 4'd7;
    localparam state_t HALT = 4'd8;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_OR   = 5'b01011;

    typedef struct packed {
        logic PCout, MARin, incPC, Zin;
        logic ZLowOut, ZHighOut, PCin, read, write, MDRin, MDRout, IRin;
        logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, CONN_in;
        logic HIin, LOin, HIout, LOout, InPortIn, InPortOut, OutPortIn;
        logic [4:0] opcode;
        logic run;
    } ctrl_t;

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-to-datapath control bus; mem_rdy exists only when CTRL_MEM_WAIT_EN is defined.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con_ff;
`ifdef CTRL_MEM_WAIT_EN
    logic        mem_rdy;
`endif
    logic PCout, MARin, incPC, Zin;
    logic ZLowOut, ZHighOut, PCin, read, write, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, CONN_in;
    logic HIin, LOin, HIout, LOout, InPortIn, InPortOut, OutPortIn;
    logic [4:0] opcode;
    logic       run;

    modport master (
        input  ir, con_ff,
`ifdef CTRL_MEM_WAIT_EN
        input  mem_rdy,
`endif
        output PCout, MARin, incPC, Zin,
        output ZLowOut, ZHighOut, PCin, read, write, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, CONN_in,
        output HIin, LOin, HIout, LOout, InPortIn, InPortOut, OutPortIn,
        output opcode, run
    );

    modport slave (
        output ir, con_ff,
`ifdef CTRL_MEM_WAIT_EN
        output mem_rdy,
`endif
        input  PCout, MARin, incPC, Zin,
        input  ZLowOut, ZHighOut, PCin, read, write, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, CONN_in,
        input  HIin, LOin, HIout, LOout, InPortIn, InPortOut, OutPortIn,
        input  opcode, run
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from (state, opcode, con_ff); special-register
// strobes are left at 0 in this revision.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    input  logic       con_ff,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != HALT);
        case (state)
            T0: begin ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.incPC = 1'b1; ctrl.Zin = 1'b1; end
            T1: begin ctrl.ZLowOut = 1'b1; ctrl.PCin = 1'b1; ctrl.read = 1'b1; ctrl.MDRin = 1'b1; end
            T2: begin ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
            T3: case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                    begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                OP_LDI, OP_LD, OP_ST:
                    begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1; end
                OP_BR:  begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONN_in = 1'b1; end
                OP_JR:  begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
                OP_JAL: begin ctrl.PCout = 1'b1; ctrl.Grb = 1'b1; ctrl.Rin = 1'b1; end
                default: ;
            endcase
            T4: case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1;
                    ctrl.opcode = alu_code(op);
                end
                OP_ADDI, OP_LDI, OP_LD, OP_ST:
                    begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; ctrl.opcode = ALU_ADD; end
                OP_BR:  begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
                OP_JAL: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
                default: ;
            endcase
            T5: case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                    begin ctrl.ZLowOut = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                OP_LD, OP_ST: begin ctrl.ZLowOut = 1'b1; ctrl.MARin = 1'b1; end
                OP_BR: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; ctrl.opcode = ALU_ADD; end
                default: ;
            endcase
            T6: case (op)
                OP_LD: begin ctrl.read = 1'b1; ctrl.MDRin = 1'b1; end
                OP_ST: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1; end
                OP_BR: if (con_ff) begin ctrl.ZLowOut = 1'b1; ctrl.PCin = 1'b1; end
                default: ;
            endcase
            T7: case (op)
                OP_LD: begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                OP_ST: ctrl.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: state register and next-state logic only.
// Optional memory wait-states on T1, ld T6 and st T7 when CTRL_MEM_WAIT_EN is defined.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);

    state_t     state_q, state_d;
    logic [4:0] op;
    logic       mem_ok;
    ctrl_t      dec, ctrl;
    logic       unused_ir;

    assign op        = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = bus.mem_rdy;
`else
    assign mem_ok = 1'b1;
`endif

    // T0-T2 fetch | T3-T7 execute | HALT stopped until clr
    always_comb begin
        state_d = state_q;
        case (state_q)
            T0: state_d = T1;
            T1: if (mem_ok) state_d = T2;
            T2: state_d = T3;
            T3: case (op)
                OP_HALT: state_d = HALT;
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI,
                OP_LD, OP_ST, OP_BR, OP_JAL: state_d = T4;
                default: state_d = T0;
            endcase
            T4: state_d = (op == OP_JAL) ? T0 : T5;
            T5: state_d = (op == OP_LD || op == OP_ST || op == OP_BR) ? T6 : T0;
            T6: begin
                if (op == OP_ST || (op == OP_LD && mem_ok)) state_d = T7;
                else if (op != OP_LD)                       state_d = T0;
            end
            T7: if (op != OP_ST || mem_ok) state_d = T0;
            HALT: state_d = HALT;
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= T0;
        else     state_q <= state_d;
    end

    ctrl_decode u_decode (
        .state  (state_q),
        .op     (op),
        .con_ff (bus.con_ff),
        .ctrl   (dec)
    );

    // Strobes stay quiet while clr is held, even if the old state is mid-instruction.
    always_comb begin
        ctrl = dec;
        if (clr) begin
            ctrl     = '0;
            ctrl.run = 1'b1;
        end
    end

    assign bus.PCout     = ctrl.PCout;
    assign bus.MARin     = ctrl.MARin;
    assign bus.incPC     = ctrl.incPC;
    assign bus.Zin       = ctrl.Zin;
    assign bus.ZLowOut   = ctrl.ZLowOut;
    assign bus.ZHighOut  = ctrl.ZHighOut;
    assign bus.PCin      = ctrl.PCin;
    assign bus.read      = ctrl.read;
    assign bus.write     = ctrl.write;
    assign bus.MDRin     = ctrl.MDRin;
    assign bus.MDRout    = ctrl.MDRout;
    assign bus.IRin      = ctrl.IRin;
    assign bus.Gra       = ctrl.Gra;
    assign bus.Grb       = ctrl.Grb;
    assign bus.Grc       = ctrl.Grc;
    assign bus.Rin       = ctrl.Rin;
    assign bus.Rout      = ctrl.Rout;
    assign bus.BAout     = ctrl.BAout;
    assign bus.Cout      = ctrl.Cout;
    assign bus.Yin       = ctrl.Yin;
    assign bus.CONN_in   = ctrl.CONN_in;
    assign bus.HIin      = ctrl.HIin;
    assign bus.LOin      = ctrl.LOin;
    assign bus.HIout     = ctrl.HIout;
    assign bus.LOout     = ctrl.LOout;
    assign bus.InPortIn  = ctrl.InPortIn;
    assign bus.InPortOut = ctrl.InPortOut;
    assign bus.OutPortIn = ctrl.OutPortIn;
    assign bus.opcode    = ctrl.opcode;
    assign bus.run       = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction microstep table model checked every
// cycle, plus directed literal checks from the test plan (mem-wait part under CTRL_MEM_WAIT_EN).
module tb_control_sequencer;

    localparam logic [4:0] I_LD = 5'b00000, I_LDI = 5'b00001, I_ST = 5'b00010;
    localparam logic [4:0] I_ADD = 5'b00011, I_SUB = 5'b00100, I_AND = 5'b00101, I_OR = 5'b00110;
    localparam logic [4:0] I_ADDI = 5'b01100, I_BR = 5'b10011, I_JR = 5'b10100, I_JAL = 5'b10101;
    localparam logic [4:0] I_HALT = 5'b11011;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if bus ();
    control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

    string names [28] = '{"PCout", "MARin", "incPC", "Zin", "ZLowOut", "ZHighOut", "PCin",
                          "read", "write", "MDRin", "MDRout", "IRin", "Gra", "Grb", "Grc",
                          "Rin", "Rout", "BAout", "Cout", "Yin", "CONN_in", "HIin", "LOin",
                          "HIout", "LOout", "InPortIn", "InPortOut", "OutPortIn"};

    logic [33:0] obs_v, exp_v;
    assign obs_v = {bus.run, bus.opcode, bus.PCout, bus.MARin, bus.incPC, bus.Zin,
                    bus.ZLowOut, bus.ZHighOut, bus.PCin, bus.read, bus.write, bus.MDRin,
                    bus.MDRout, bus.IRin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                    bus.BAout, bus.Cout, bus.Yin, bus.CONN_in, bus.HIin, bus.LOin, bus.HIout,
                    bus.LOout, bus.InPortIn, bus.InPortOut, bus.OutPortIn};
    wire t0_sig = bus.PCout & bus.MARin & bus.incPC & bus.Zin;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    endtask

    // ---- model: microstep k counted from T0, expressed as the strobe list for that step
    function automatic string seq_step(input logic [4:0] op, input int k, input logic c);
        if (k == 0) return "PCout MARin incPC Zin";
        if (k == 1) return "ZLowOut PCin read MDRin";
        if (k == 2) return "MDRout IRin";
        case (op)
            I_ADD, I_SUB, I_AND, I_OR:
                case (k) 3: return "Grb Rout Yin"; 4: return "Grc Rout Zin";
                         5: return "ZLowOut Gra Rin"; default: return ""; endcase
            I_ADDI, I_LDI:
                case (k) 3: return (op == I_ADDI) ? "Grb Rout Yin" : "Grb BAout Yin";
                         4: return "Cout Zin"; 5: return "ZLowOut Gra Rin";
                         default: return ""; endcase
            I_LD, I_ST:
                case (k) 3: return "Grb BAout Yin"; 4: return "Cout Zin";
                         5: return "ZLowOut MARin";
                         6: return (op == I_LD) ? "read MDRin" : "Gra Rout MDRin";
                         7: return (op == I_LD) ? "MDRout Gra Rin" : "write";
                         default: return ""; endcase
            I_BR:
                case (k) 3: return "Gra Rout CONN_in"; 4: return "PCout Yin";
                         5: return "Cout Zin"; 6: return c ? "ZLowOut PCin" : "";
                         default: return ""; endcase
            I_JR:  return (k == 3) ? "Gra Rout PCin" : "";
            I_JAL:
                case (k) 3: return "PCout Grb Rin"; 4: return "Gra Rout PCin";
                         default: return ""; endcase
            default: return "";
        endcase
    endfunction

    function automatic logic [4:0] exp_alu(input logic [4:0] op, input int k);
        if (k == 4) begin
            case (op)
                I_ADD, I_ADDI, I_LDI, I_LD, I_ST: return 5'b00001;
                I_SUB: return 5'b00010;
                I_AND: return 5'b01010;
                I_OR:  return 5'b01011;
                default: return 5'b00000;
            endcase
        end
        if (k == 5 && op == I_BR) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic int seq_len(input logic [4:0] op);
        case (op)
            I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_LDI: return 6;
            I_LD, I_ST: return 8;
            I_BR: return 7;
            I_JAL: return 5;
            default: return 4;
        endcase
    endfunction

    function automatic logic [27:0] mask_of(input string s);
        logic [27:0] m;
        string tok;
        m = '0;
        tok = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == 8'h20) begin
                if (tok.len() > 0)
                    for (int j = 0; j < 28; j++) if (names[j] == tok) m[27-j] = 1'b1;
                tok = "";
            end else begin
                tok = {tok, s.substr(i, i)};
            end
        end
        return m;
    endfunction

    int   m_k = 0;
    logic m_halt = 1'b0;
    logic chk_en = 1'b0;
    wire [4:0] m_op = bus.ir[31:27];
    logic m_hold;
`ifdef CTRL_MEM_WAIT_EN
    assign m_hold = !bus.mem_rdy && (m_k == 1 || (m_k == 6 && m_op == I_LD) || (m_k == 7 && m_op == I_ST));
`else
    assign m_hold = 1'b0;
`endif

    always @(posedge clk) begin
        if (clr) begin
            m_k    <= 0;
            m_halt <= 1'b0;
        end else if (!m_halt && !m_hold) begin
            if (m_k == 3 && m_op == I_HALT)   m_halt <= 1'b1;
            else if (m_k + 1 == seq_len(m_op)) m_k <= 0;
            else                               m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (clr)         exp_v = {1'b1, 33'b0};
            else if (m_halt) exp_v = '0;
            else exp_v = {1'b1, exp_alu(m_op, m_k), mask_of(seq_step(m_op, m_k, bus.con_ff))};
            check($sformatf("cycle k=%0d", m_k), obs_v, exp_v);
        end
    end

    // ---- directed part
    logic [33:0] snap [20];
    function automatic logic sb(input int n, input string nm);
        for (int j = 0; j < 28; j++) if (names[j] == nm) return snap[n][27-j];
        return 1'bx;
    endfunction
    function automatic logic [7:0] ones(input int n);
        return 8'($countones(snap[n][27:0]));
    endfunction

    // Call at the negedge of a T0 cycle; returns at the negedge of the following T0.
    task automatic run_instr(input logic [31:0] iv, input logic c, output int len);
        bus.ir     = iv;
        bus.con_ff = c;
        len = 0;
        for (int n = 0; n < 20; n++) begin
            snap[n] = obs_v;
            @(negedge clk);
            len++;
            if (t0_sig) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, bad, cnt;
        bus.ir = 32'hD000_0000;
        bus.con_ff = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        bus.mem_rdy = 1'b1;
`endif
        clr = 1'b1;
        @(posedge clk); #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", obs_v, {1'b1, 33'b0});
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("first_fetch", {t0_sig, 8'($countones(obs_v[27:0]))}, {1'b1, 8'd4});

        run_instr(32'h1880_0000, 1'b0, len);
        check("add_len", len, 6);
        check("add_T4", {sb(4,"Grc"), sb(4,"Rout"), sb(4,"Zin"), snap[4][32:28], ones(4)}, {3'b111, 5'b00001, 8'd3});
        check("add_T5", {sb(5,"ZLowOut"), sb(5,"Gra"), sb(5,"Rin"), ones(5)}, {3'b111, 8'd3});

        run_instr(32'h9B08_0019, 1'b1, len);
        check("br_taken_len", len, 7);
        check("br_taken_T6", {sb(6,"ZLowOut"), sb(6,"PCin"), ones(6)}, {2'b11, 8'd2});
        run_instr(32'h9B08_0019, 1'b0, len);
        check("br_not_len", len, 7);
        check("br_not_T6", ones(6), 8'd0);

        run_instr(32'h0000_0000, 1'b0, len);
        check("ld_len", len, 8);
        check("ld_T6", {sb(6,"read"), sb(6,"MDRin"), ones(6)}, {2'b11, 8'd2});
        check("ld_T7", {sb(7,"MDRout"), sb(7,"Gra"), sb(7,"Rin"), ones(7)}, {3'b111, 8'd3});
        run_instr(32'h1000_0000, 1'b0, len);
        check("st_len", len, 8);
        check("st_T7", {sb(7,"write"), ones(7)}, {1'b1, 8'd1});

        run_instr(32'h2000_0000, 1'b0, len);
        check("sub_op", snap[4][32:28], 5'b00010);
        run_instr(32'h2800_0000, 1'b0, len);
        check("and_op", snap[4][32:28], 5'b01010);
        run_instr(32'h3000_0000, 1'b0, len);
        check("or_op", snap[4][32:28], 5'b01011);
        run_instr(32'h6000_0000, 1'b0, len);
        check("addi", {len[7:0], sb(4,"Cout"), sb(4,"Zin"), snap[4][32:28]}, {8'd6, 2'b11, 5'b00001});
        run_instr(32'h0800_0000, 1'b0, len);
        check("ldi", {len[7:0], sb(3,"BAout"), sb(3,"Rout")}, {8'd6, 2'b10});
        run_instr(32'hA800_0000, 1'b0, len);
        check("jal", {len[7:0], sb(3,"PCout"), sb(3,"Grb"), sb(3,"Rin")}, {8'd5, 3'b111});
        run_instr(32'hA000_0000, 1'b0, len);
        check("jr_len", len, 4);
        run_instr(32'hD000_0000, 1'b0, len);
        check("nop_len", len, 4);
        run_instr(32'hF800_0000, 1'b0, len);
        check("undef", {len[7:0], ones(3)}, {8'd4, 8'd0});

        // clr pulse during ld T5
        bus.ir = 32'h0000_0000;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        check("clr_mid_zero", obs_v, {1'b1, 33'b0});
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("clr_mid_T0", {t0_sig, 8'($countones(obs_v[27:0]))}, {1'b1, 8'd4});

        // halt, hold 20 cycles, resume on clr
        bus.ir = 32'hD800_0000;
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs_v !== 34'd0) bad++;
            @(negedge clk);
        end
        check("halt_hold", bad, 0);
        @(posedge clk); #1 clr = 1'b1; bus.ir = 32'hD000_0000;
        @(negedge clk);
        check("halt_clr_run", {bus.run, 8'($countones(obs_v[27:0]))}, {1'b1, 8'd0});
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("halt_resume", {bus.run, t0_sig}, 2'b11);

`ifdef CTRL_MEM_WAIT_EN
        cnt = 0;
        @(posedge clk); #1 bus.mem_rdy = 1'b0;
        @(negedge clk); cnt += int'(bus.ZLowOut & bus.PCin & bus.read & bus.MDRin);
        @(negedge clk); cnt += int'(bus.ZLowOut & bus.PCin & bus.read & bus.MDRin);
        @(negedge clk); cnt += int'(bus.ZLowOut & bus.PCin & bus.read & bus.MDRin);
        @(posedge clk); #1 bus.mem_rdy = 1'b1;
        @(negedge clk); cnt += int'(bus.ZLowOut & bus.PCin & bus.read & bus.MDRin);
        @(negedge clk);
        check("memwait_T1", cnt, 4);
        check("memwait_T2", {bus.MDRout, bus.IRin}, 2'b11);
        cnt = 0;
        while (!t0_sig && cnt < 20) begin @(negedge clk); cnt++; end
        check("memwait_back_T0", t0_sig, 1'b1);
`else
        cnt = 0;
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
